// File: rtl/dmem_responder.sv
// Word-addressed data-memory responder: accepts one read or write, holds it for
// LATENCY cycles (frozen by stall while BUSY), then pulses dmem_resp for one cycle.
module dmem_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_WORDS  = 256,
  parameter int LATENCY    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] dmem_addr,
  input  logic [3:0]            dmem_rmask,
  input  logic [3:0]            dmem_wmask,
  input  logic [DATA_WIDTH-1:0] dmem_wdata,
  output logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic                  dmem_resp,
  input  logic                  stall,
  output logic                  proto_err,
  output logic [15:0]           rd_count,
  output logic [15:0]           wr_count
);

  localparam int IW    = $clog2(MEM_WORDS);
  localparam int LANES = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                state, state_nxt;
  logic [3:0]            cnt, cnt_nxt;
  logic [IW-1:0]         lat_idx;
  logic [3:0]            lat_wmask;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic                  lat_write;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic                  req_rd, req_wr, req_ok, req_err;
  logic [IW-1:0]         req_idx, resp_idx;
  logic                  resp_is_write;
  logic                  resp_nxt, perr_nxt;
  logic [DATA_WIDTH-1:0] rdata_nxt;
  logic [15:0]           rd_nxt, wr_nxt;
  logic                  unused_addr_bits;

  assign req_rd   = |dmem_rmask;
  assign req_wr   = |dmem_wmask;
  assign req_ok   = req_rd ^ req_wr;
  assign req_err  = req_rd & req_wr;
  assign req_idx  = dmem_addr[IW+1:2];
  assign unused_addr_bits = ^{dmem_addr[ADDR_WIDTH-1:IW+2], dmem_addr[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (req_ok) begin
          cnt_nxt   = 4'(LATENCY - 1);
          state_nxt = (LATENCY == 1) ? RESP : BUSY;
        end
      end
      BUSY: begin
        if (!stall) begin
          if (cnt == 4'd1) state_nxt = RESP;
          else             cnt_nxt   = cnt - 4'd1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered, so compute them for the state being entered.
  // With LATENCY==1 RESP is entered straight from IDLE, before the latches load.
  always_comb begin
    resp_is_write = (state == IDLE) ? req_wr  : lat_write;
    resp_idx      = (state == IDLE) ? req_idx : lat_idx;
    resp_nxt      = (state_nxt == RESP);
    rdata_nxt     = (resp_nxt && !resp_is_write) ? mem[resp_idx] : '0;
    perr_nxt      = proto_err | ((state == IDLE) & req_err);
    rd_nxt        = rd_count + 16'(resp_nxt && !resp_is_write);
    wr_nxt        = wr_count + 16'(resp_nxt && resp_is_write);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dmem_resp  <= 1'b0;
      dmem_rdata <= '0;
      proto_err  <= 1'b0;
      rd_count   <= '0;
      wr_count   <= '0;
      lat_idx    <= '0;
      lat_wmask  <= '0;
      lat_wdata  <= '0;
      lat_write  <= 1'b0;
    end else begin
      dmem_resp  <= resp_nxt;
      dmem_rdata <= rdata_nxt;
      proto_err  <= perr_nxt;
      rd_count   <= rd_nxt;
      wr_count   <= wr_nxt;
      if (state == IDLE && req_ok) begin
        lat_idx   <= req_idx;
        lat_wmask <= dmem_wmask;
        lat_wdata <= dmem_wdata;
        lat_write <= req_wr;
      end
    end
  end

  // Writes commit on the edge that ends RESP; a reset before then drops them.
  always_ff @(posedge clk) begin
    if (state == RESP && lat_write) begin
      for (int i = 0; i < LANES; i++) begin
        if (lat_wmask[i]) mem[lat_idx][8*i +: 8] <= lat_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized scoreboard bench for dmem_responder: the driver models memory and
// counters at transaction level, a monitor pops expected responses on dmem_resp.
module tb_dmem_responder;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int MW  = 256;
  localparam int LAT = 3;

  // clock/reset block
  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] dmem_addr;
  logic [3:0]    dmem_rmask, dmem_wmask;
  logic [DW-1:0] dmem_wdata, dmem_rdata;
  logic          dmem_resp, stall, proto_err;
  logic [15:0]   rd_count, wr_count;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_WORDS(MW), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask),
    .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_resp(dmem_resp), .stall(stall), .proto_err(proto_err),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  // reference model and scoreboard
  int          passed = 0;
  int          total  = 0;
  logic [63:0] exp_q[$];
  logic [31:0] model_mem [MW];
  logic [15:0] m_rd = '0;
  logic [15:0] m_wr = '0;
  logic        m_perr = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && dmem_resp === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_resp: got resp with rdata %0h, expected no response", dmem_rdata);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("resp_payload{rd,wr,rdata}", {rd_count, wr_count, dmem_rdata}, e);
      end
    end
  end

  // driver: caller guarantees the DUT is IDLE in the current cycle
  task automatic issue(input logic [31:0] addr, input logic is_wr, input logic [3:0] mask,
                       input logic [31:0] wdata, input int stall_first, input int stall_pct,
                       input bit hold);
    int          idx;
    int          free;
    bit          exp_r, done;
    logic [31:0] exp_data;
    idx  = int'((addr >> 2) % MW);
    free = 0;
    done = 0;
    if (is_wr) begin
      for (int i = 0; i < 4; i++) if (mask[i]) model_mem[idx][8*i +: 8] = wdata[8*i +: 8];
      m_wr++;
      exp_data = '0;
    end else begin
      m_rd++;
      exp_data = model_mem[idx];
    end
    exp_q.push_back({m_rd, m_wr, exp_data});
    dmem_addr  = addr;
    dmem_rmask = is_wr ? 4'h0 : mask;
    dmem_wmask = is_wr ? mask : 4'h0;
    dmem_wdata = wdata;
    @(posedge clk); #1;
    for (int c = 0; c < 64 && !done; c++) begin
      if (!hold) begin
        dmem_addr  = $urandom;
        dmem_wdata = $urandom;
        dmem_rmask = 4'($urandom);
        dmem_wmask = 4'($urandom);
      end
      stall = (c < stall_first) || (32'($urandom_range(99)) < 32'(stall_pct));
      exp_r = (free == LAT - 1);
      @(negedge clk);
      check("resp_timing", {63'd0, dmem_resp}, {63'd0, exp_r});
      check("proto_err", {63'd0, proto_err}, {63'd0, m_perr});
      if (exp_r || dmem_resp) done = 1;
      else if (!stall) free++;
      @(posedge clk); #1;
    end
    if (!done) begin
      total++;
      $display("FAIL resp_timeout: got no resp within 64 cycles, expected one");
    end
    stall = 1'b0;
    if (!hold) begin
      dmem_rmask = 4'h0;
      dmem_wmask = 4'h0;
    end
    @(negedge clk);
    check("resp_after", {63'd0, dmem_resp}, 64'd0);
    check("rdata_after", {32'd0, dmem_rdata}, 64'd0);
  endtask

  initial begin
    logic [31:0] a;
    for (int i = 0; i < MW; i++) model_mem[i] = '0;
    dmem_addr = '0; dmem_rmask = '0; dmem_wmask = '0; dmem_wdata = '0; stall = 1'b0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    check("reset_outputs", {dmem_resp, proto_err, rd_count, wr_count, dmem_rdata}, 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // write then read back, full word
    issue(32'h10, 1'b1, 4'hF, 32'hDEADBEEF, 0, 0, 0);
    issue(32'h10, 1'b0, 4'hF, 32'h0, 0, 0, 0);
    // partial write merges lanes 0 and 2 into the old word
    issue(32'h20, 1'b1, 4'hF, 32'h11223344, 0, 0, 0);
    issue(32'h20, 1'b1, 4'b0101, 32'hAABBCCDD, 0, 0, 0);
    issue(32'h20, 1'b0, 4'h1, 32'h0, 0, 0, 0);
    // four stalled cycles right after acceptance push resp out by four
    issue(32'h10, 1'b0, 4'hF, 32'h0, 4, 0, 0);
    // identical request held across resp is a second transaction; then alias read
    issue(32'h30, 1'b1, 4'hF, 32'hCAFEF00D, 0, 0, 1);
    issue(32'h30, 1'b1, 4'hF, 32'hCAFEF00D, 0, 0, 0);
    issue(32'h430, 1'b0, 4'hF, 32'h0, 0, 0, 0);

    // both masks in IDLE: sticky error, nothing accepted
    dmem_addr = 32'h50; dmem_rmask = 4'hF; dmem_wmask = 4'h1;
    @(posedge clk); #1;
    dmem_rmask = 4'h0; dmem_wmask = 4'h0;
    m_perr = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("proto_err_sticky", {63'd0, proto_err}, 64'd1);
      check("perr_no_resp", {63'd0, dmem_resp}, 64'd0);
      check("perr_counters", {32'd0, rd_count, wr_count}, {32'd0, m_rd, m_wr});
    end
    issue(32'h20, 1'b0, 4'hF, 32'h0, 0, 0, 0);

    // reset in the middle of a write drops it
    dmem_addr = 32'h40; dmem_wmask = 4'hF; dmem_wdata = 32'h5A5A5A5A;
    @(posedge clk); #1;
    dmem_wmask = 4'h0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midreset_outputs", {dmem_resp, proto_err, rd_count, wr_count, dmem_rdata}, 64'd0);
    m_rd = '0; m_wr = '0; m_perr = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    issue(32'h40, 1'b0, 4'hF, 32'h0, 0, 0, 0);

    // randomized traffic over a few words with random aliasing and stalls
    for (int n = 0; n < 150; n++) begin
      a = $urandom;
      a[9:2] = 8'($urandom_range(0, 15));
      issue(a, 1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), $urandom,
            0, $urandom_range(0, 50), 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
